// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: three-flop synchronizer, mid-bit sampling FSM, and
// one-cycle valid / framing-error / break strobes.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       break_det,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  logic          r_s1, r_s2, r_s3;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;

  // s3 resets low, so the line must be seen high before a falling edge counts.
  logic w_start_edge;
  assign w_start_edge = !r_s2 && r_s3;

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // mixing in blocking assignments would make later reads see same-cycle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sh      <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_s1      <= rx;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_start_edge) begin
            r_state <= START;
            r_cnt   <= CW'(HALF_BIT - 1);
            busy    <= 1'b1;
          end
        end

        START: begin
          if (r_cnt == '0) begin
            if (r_s2) begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= DATA;
              r_cnt   <= CW'(CLKS_PER_BIT - 1);
              r_idx   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        DATA: begin
          if (r_cnt == '0) begin
            r_sh  <= {r_s2, r_sh[7:1]};
            r_cnt <= CW'(CLKS_PER_BIT - 1);
            if (r_idx == 3'd7) r_state <= STOP;
            else               r_idx   <= r_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        STOP: begin
          // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
          if (r_cnt == '0) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            if (r_s2) begin
              data  <= r_sh;
              valid <= 1'b1;
            end else if (r_sh != 8'h00) begin
              frame_err <= 1'b1;
            end else begin
              break_det <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed plus randomized bench for uart_byte_rx; expected strobes come from
// a frame-level model of the 8N1 receive rules.
module tb_uart_byte_rx;

  localparam int CPB   = 16;
  localparam int LAT   = 155;   // rx fall stamp -> strobe stamp (T0+153 plus sync/edge)
  localparam int LOG_N = 32768;

  typedef struct {
    int         cyc;
    logic [2:0] kind;   // {valid, frame_err, break_det}
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid, frame_err, break_det, busy;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic busy_log [LOG_N];
  ev_t  ev_q [$];
  logic [7:0] model_data;

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .break_det (break_det),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOG_N) busy_log[cyc] = busy;
    if (valid || frame_err || break_det)
      ev_q.push_back(ev_t'{cyc, {valid, frame_err, break_det}, data});
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      rx = v;
      @(negedge clk);
    end
  endtask

  // Drives the first ncyc cycles of a frame; bit period is per10/10 clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per10,
                            input int ncyc, output int f);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    f = cyc;
    for (int c = 0; c < ncyc; c++) begin
      rx = bits[(c * 10) / per10];
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input int f, input logic [7:0] b,
                             input logic stop_ok);
    logic [2:0] exp_kind;
    ev_t e, first;
    int  n;
    exp_kind = stop_ok ? 3'b100 : ((b != 8'h00) ? 3'b010 : 3'b001);
    if (stop_ok) model_data = b;
    while (cyc < f + LAT + 2) @(negedge clk);
    n = 0;
    first = ev_t'{0, 3'b000, 8'h00};
    while (ev_q.size() > 0 && ev_q[0].cyc < f + LAT + 3) begin
      e = ev_q.pop_front();
      if (n == 0) first = e;
      n++;
    end
    check({tag, "_strobe_count"}, n, 1);
    if (n > 0) begin
      check({tag, "_strobe_cycle"}, first.cyc - f, LAT);
      check({tag, "_strobe_kind"}, first.kind, exp_kind);
      check({tag, "_data"}, first.data, model_data);
    end
    check({tag, "_busy_mid"}, busy_log[f + 4], 1'b1);
    check({tag, "_busy_after"}, busy_log[f + LAT + 1], 1'b0);
  endtask

  initial begin
    int f, f1, f2, per10, gap;
    logic [7:0] b;
    logic stop_ok;
    int periods [3] = '{155, 160, 165};

    reset = 1'b1;
    rx    = 1'b1;
    model_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_break_det", break_det, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Line low across reset release must not be taken as a start.
    rx = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 20);
    check("low_thru_reset_busy", busy, 1'b0);
    check("low_thru_reset_events", ev_q.size(), 0);
    drive(1'b1, 10);

    send_frame(8'hA5, 1'b1, 160, 160, f);
    check_frame("a5", f, 8'hA5, 1'b1);

    send_frame(8'h00, 1'b1, 160, 160, f1);
    send_frame(8'hFF, 1'b1, 160, 160, f2);
    check_frame("b2b_00", f1, 8'h00, 1'b1);
    check_frame("b2b_ff", f2, 8'hFF, 1'b1);
    drive(1'b1, 5);

    f = cyc;
    drive(1'b0, 3);
    drive(1'b1, 30);
    check("glitch_busy_start", busy_log[f + 5], 1'b1);
    check("glitch_busy_idle", busy_log[f + 12], 1'b0);
    check("glitch_events", ev_q.size(), 0);
    check("glitch_data", data, model_data);

    send_frame(8'h55, 1'b0, 160, 160, f);
    drive(1'b1, 4);
    check_frame("ferr_55", f, 8'h55, 1'b0);
    check("ferr_data_held", data, model_data);

    f = cyc;
    drive(1'b0, 12 * CPB);
    check("break_no_retrigger", busy_log[f + LAT + 30], 1'b0);
    drive(1'b1, 10);
    check_frame("break", f, 8'h00, 1'b0);
    check("break_extra_events", ev_q.size(), 0);
    send_frame(8'h3C, 1'b1, 160, 160, f);
    check_frame("after_break_3c", f, 8'h3C, 1'b1);
    drive(1'b1, 5);

    send_frame(8'h81, 1'b1, 160, 85, f);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    check("midrst_data", data, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_strobes", {valid, frame_err, break_det}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    model_data = 8'h00;
    drive(1'b1, 200);
    check("midrst_busy_after", busy, 1'b0);
    check("midrst_events", ev_q.size(), 0);
    check("midrst_data_after", data, 8'h00);
    send_frame(8'h81, 1'b1, 160, 160, f);
    check_frame("after_rst_81", f, 8'h81, 1'b1);

    for (int i = 0; i < 20; i++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 9) != 0);
      per10   = periods[$urandom_range(0, 2)];
      gap     = $urandom_range(0, 12);
      send_frame(b, stop_ok, per10, per10, f);
      drive(1'b1, stop_ok ? gap : gap + 2);
      check_frame("rand", f, b, stop_ok);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
